// File: rtl/iobus_pkg.sv
// Shared opcode and state encodings for the IO bus master sequencer.
package iobus_pkg;

   localparam int unsigned DEV_W  = 7;
   localparam int unsigned WORD_W = 36;

   typedef enum logic [1:0] {
      OP_CONO  = 2'd0,
      OP_DATAO = 2'd1,
      OP_CONI  = 2'd2,
      OP_DATAI = 2'd3
   } iob_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_SET    = 3'd2,
      ST_SETTLE = 3'd3,
      ST_RESP   = 3'd4,
      ST_BRST   = 3'd5
   } iob_state_e;

   function automatic logic op_is_write(input iob_op_e op);
      return (op == OP_CONO) || (op == OP_DATAO);
   endfunction

endpackage

// File: rtl/iobus_master_seq.sv
// IO bus master: sequences CONO/DATAO/CONI/DATAI strobes and bus reset pulses
// from a valid/ready command port, returning a one-cycle completion pulse.
module iobus_master_seq
   import iobus_pkg::*;
#(
   parameter int unsigned CLR_CYC    = 2,
   parameter int unsigned SET_CYC    = 2,
   parameter int unsigned SETTLE_CYC = 3,
   parameter int unsigned RST_CYC    = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [3:9]        cmd_dev,
   input  logic [0:WORD_W-1] cmd_data,
   output logic              rsp_valid,
   output logic [0:WORD_W-1] rsp_data,
   input  logic              bus_reset_req,
   output logic              busy,
   output logic              iob_reset,
   output logic              datao_clear,
   output logic              datao_set,
   output logic              cono_clear,
   output logic              cono_set,
   output logic              iob_fm_datai,
   output logic              iob_fm_status,
   output logic [3:9]        ios,
   output logic [0:WORD_W-1] iob_write,
   input  logic [0:WORD_W-1] iob_read
);

   localparam int unsigned MAX_AB  = (CLR_CYC > SET_CYC) ? CLR_CYC : SET_CYC;
   localparam int unsigned MAX_CD  = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   if (CLR_CYC == 0 || SET_CYC == 0 || SETTLE_CYC == 0 || RST_CYC == 0) begin : g_bad_param
      $error("iobus_master_seq: cycle-count parameters must be non-zero");
   end

   iob_state_e         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_pend;
   iob_op_e            r_op;
   logic [3:9]         r_dev;
   logic [0:WORD_W-1]  r_data;
   logic               w_accept;
   iob_op_e            w_op;

   // Ready is a decode of registered state gated by the live reset request,
   // so a request arriving in IDLE blocks acceptance in the same cycle.
   assign cmd_ready = reset & (r_state == ST_IDLE) & ~r_pend & ~bus_reset_req;
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_op      = iob_op_e'(cmd_op);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_pend        <= 1'b0;
         r_op          <= OP_CONO;
         r_dev         <= '0;
         r_data        <= '0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         busy          <= 1'b0;
         iob_reset     <= 1'b0;
         datao_clear   <= 1'b0;
         datao_set     <= 1'b0;
         cono_clear    <= 1'b0;
         cono_set      <= 1'b0;
         iob_fm_datai  <= 1'b0;
         iob_fm_status <= 1'b0;
         ios           <= '0;
         iob_write     <= '0;
      end else begin
         // Outputs describe the state being entered; everything idles low.
         rsp_valid     <= 1'b0;
         busy          <= 1'b1;
         iob_reset     <= 1'b0;
         datao_clear   <= 1'b0;
         datao_set     <= 1'b0;
         cono_clear    <= 1'b0;
         cono_set      <= 1'b0;
         iob_fm_datai  <= 1'b0;
         iob_fm_status <= 1'b0;
         ios           <= '0;
         iob_write     <= '0;
         r_pend        <= r_pend | bus_reset_req;

         case (r_state)
            ST_IDLE: begin
               busy <= 1'b0;
               if (r_pend || bus_reset_req) begin
                  r_state   <= ST_BRST;
                  r_cnt     <= CNT_W'(RST_CYC - 1);
                  iob_reset <= 1'b1;
                  busy      <= 1'b1;
               end else if (w_accept) begin
                  r_op   <= w_op;
                  r_dev  <= cmd_dev;
                  r_data <= cmd_data;
                  ios    <= cmd_dev;
                  busy   <= 1'b1;
                  if (op_is_write(w_op)) begin
                     r_state     <= ST_CLR;
                     r_cnt       <= CNT_W'(CLR_CYC - 1);
                     cono_clear  <= (w_op == OP_CONO);
                     datao_clear <= (w_op == OP_DATAO);
                     iob_write   <= cmd_data;
                  end else begin
                     r_state       <= ST_SETTLE;
                     r_cnt         <= CNT_W'(SETTLE_CYC - 1);
                     iob_fm_status <= (w_op == OP_CONI);
                     iob_fm_datai  <= (w_op == OP_DATAI);
                  end
               end
            end
            ST_CLR: begin
               ios       <= r_dev;
               iob_write <= r_data;
               if (r_cnt == '0) begin
                  r_state   <= ST_SET;
                  r_cnt     <= CNT_W'(SET_CYC - 1);
                  cono_set  <= (r_op == OP_CONO);
                  datao_set <= (r_op == OP_DATAO);
               end else begin
                  r_cnt       <= r_cnt - CNT_W'(1);
                  cono_clear  <= (r_op == OP_CONO);
                  datao_clear <= (r_op == OP_DATAO);
               end
            end
            ST_SET: begin
               ios <= r_dev;
               if (r_cnt == '0) begin
                  r_state   <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
               end else begin
                  r_cnt     <= r_cnt - CNT_W'(1);
                  iob_write <= r_data;
                  cono_set  <= (r_op == OP_CONO);
                  datao_set <= (r_op == OP_DATAO);
               end
            end
            ST_SETTLE: begin
               ios <= r_dev;
               if (r_cnt == '0) begin
                  r_state   <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= iob_read;
               end else begin
                  r_cnt         <= r_cnt - CNT_W'(1);
                  iob_fm_status <= (r_op == OP_CONI);
                  iob_fm_datai  <= (r_op == OP_DATAI);
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               busy    <= 1'b0;
            end
            ST_BRST: begin
               if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
                  r_pend  <= bus_reset_req;
                  busy    <= 1'b0;
               end else begin
                  r_cnt     <= r_cnt - CNT_W'(1);
                  iob_reset <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iobus_master_seq.sv
// Directed bench for iobus_master_seq: table of single transactions plus
// hand-written sequences for bus reset, mid-op reset and back-to-back traffic.
module tb_iobus_master_seq;
   import iobus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:9]  cmd_dev;
   logic [0:35] cmd_data;
   logic        rsp_valid;
   logic [0:35] rsp_data;
   logic        bus_reset_req;
   logic        busy;
   logic        iob_reset, datao_clear, datao_set, cono_clear, cono_set;
   logic        iob_fm_datai, iob_fm_status;
   logic [3:9]  ios;
   logic [0:35] iob_write;
   logic [0:35] iob_read;

   always #5 clk = ~clk;

   iobus_master_seq dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dev(cmd_dev), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .bus_reset_req(bus_reset_req), .busy(busy),
      .iob_reset(iob_reset), .datao_clear(datao_clear), .datao_set(datao_set),
      .cono_clear(cono_clear), .cono_set(cono_set),
      .iob_fm_datai(iob_fm_datai), .iob_fm_status(iob_fm_status),
      .ios(ios), .iob_write(iob_write), .iob_read(iob_read)
   );

   // Control-output bit positions in the sampled word
   localparam logic [9:0] S_RST  = 10'b10_0000_0000;
   localparam logic [9:0] S_DC   = 10'b01_0000_0000;
   localparam logic [9:0] S_DS   = 10'b00_1000_0000;
   localparam logic [9:0] S_CC   = 10'b00_0100_0000;
   localparam logic [9:0] S_CS   = 10'b00_0010_0000;
   localparam logic [9:0] S_FD   = 10'b00_0001_0000;
   localparam logic [9:0] S_FS   = 10'b00_0000_1000;
   localparam logic [9:0] S_RV   = 10'b00_0000_0100;
   localparam logic [9:0] S_BUSY = 10'b00_0000_0010;
   localparam logic [9:0] S_RDY  = 10'b00_0000_0001;

   typedef struct {
      logic [1:0]  op;
      logic [3:9]  dev;
      logic [0:35] data;
      logic [0:35] rd;
      logic [0:35] exp_rsp;
   } vec_t;

   vec_t vecs [5];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0o, expected %0o", nm, act, exp);
      end
   endtask

   function automatic logic [9:0] strobes();
      return {iob_reset, datao_clear, datao_set, cono_clear, cono_set,
              iob_fm_datai, iob_fm_status, rsp_valid, busy, cmd_ready};
   endfunction

   // Expected control word c cycles after the accept cycle (c=0) for default timing.
   function automatic logic [9:0] exp_txn(input logic [1:0] op, input int c);
      if (c == 0) return S_RDY;
      if (op[1] == 1'b0) begin
         if (c <= 2) return ((op == 2'd0) ? S_CC : S_DC) | S_BUSY;
         if (c <= 4) return ((op == 2'd0) ? S_CS : S_DS) | S_BUSY;
         if (c == 5) return S_RV | S_BUSY;
         return S_RDY;
      end
      if (c <= 3) return ((op == 2'd2) ? S_FS : S_FD) | S_BUSY;
      if (c == 4) return S_RV | S_BUSY;
      return S_RDY;
   endfunction

   task automatic run_vec(input vec_t v, input string nm);
      int   last;
      logic wr;
      wr   = ~v.op[1];
      last = wr ? 5 : 4;
      cmd_op    = v.op;
      cmd_dev   = v.dev;
      cmd_data  = v.data;
      iob_read  = v.rd;
      cmd_valid = 1'b1;
      for (int c = 0; c <= last + 1; c++) begin
         @(negedge clk);
         chk({nm, "/ctl"}, 36'(strobes()), 36'(exp_txn(v.op, c)));
         chk({nm, "/ios"}, 36'(ios), (c >= 1 && c <= last) ? 36'(v.dev) : 36'd0);
         chk({nm, "/wr"}, 36'(iob_write), (wr && c >= 1 && c <= 4) ? 36'(v.data) : 36'd0);
         if (c == last)     chk({nm, "/rsp"}, 36'(rsp_data), 36'(v.exp_rsp));
         if (c == last + 1) chk({nm, "/rsp_hold"}, 36'(rsp_data), 36'(v.exp_rsp));
         @(posedge clk); #1;
         // Garbage on the command port while busy must not leak through
         if (c == 0) begin
            cmd_op   = ~v.op;
            cmd_dev  = ~v.dev;
            cmd_data = ~v.data;
         end
         if (c == last) begin
            cmd_valid = 1'b0;
            iob_read  = ~v.rd;
         end
      end
   endtask

   initial begin
      logic [9:0]  e47 [12];
      logic [9:0]  e48 [12];
      int          npulse;
      vec_t        v49;

      reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dev = '0; cmd_data = '0;
      bus_reset_req = 1'b0; iob_read = '0;

      vecs[0] = '{2'd0, 7'o014, 36'o000000000777, 36'o555,          36'o0};
      vecs[1] = '{2'd3, 7'o020, 36'o707070707070, 36'o123456701234, 36'o123456701234};
      vecs[2] = '{2'd1, 7'o177, 36'o777777777777, 36'o0,            36'o0};
      vecs[3] = '{2'd2, 7'o001, 36'o0,            36'o400000000001, 36'o400000000001};
      vecs[4] = '{2'd3, 7'o124, 36'o0,            36'o0,            36'o0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst/ctl", 36'(strobes()), 36'd0);
      chk("rst/ios", 36'(ios), 36'd0);
      chk("rst/wr", 36'(iob_write), 36'd0);
      chk("rst/rsp", 36'(rsp_data), 36'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst/ctl", 36'(strobes()), 36'(S_RDY));
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset request and command together in IDLE: reset first, command after
      e47 = '{10'd0, S_RST|S_BUSY, S_RST|S_BUSY, S_RST|S_BUSY, S_RST|S_BUSY, S_RDY,
              S_CC|S_BUSY, S_CC|S_BUSY, S_CS|S_BUSY, S_CS|S_BUSY, S_RV|S_BUSY, S_RDY};
      cmd_op = 2'd0; cmd_dev = 7'o033; cmd_data = 36'o1234;
      bus_reset_req = 1'b1; cmd_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("brst_idle/c%0d", c), 36'(strobes()), 36'(e47[c]));
         if (c == 6) chk("brst_idle/ios", 36'(ios), 36'o033);
         @(posedge clk); #1;
         if (c == 0) bus_reset_req = 1'b0;
         if (c == 5) cmd_valid = 1'b0;
      end

      // Reset request during SET does not abort the DATAO
      e48 = '{S_RDY, S_DC|S_BUSY, S_DC|S_BUSY, S_DS|S_BUSY, S_DS|S_BUSY, S_RV|S_BUSY,
              10'd0, S_RST|S_BUSY, S_RST|S_BUSY, S_RST|S_BUSY, S_RST|S_BUSY, S_RDY};
      cmd_op = 2'd1; cmd_dev = 7'o042; cmd_data = 36'o5; cmd_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("brst_mid/c%0d", c), 36'(strobes()), 36'(e48[c]));
         if (c == 4) chk("brst_mid/ios_set", 36'(ios), 36'o042);
         if (c == 5) chk("brst_mid/rsp", 36'(rsp_data), 36'd0);
         if (c == 8) chk("brst_mid/ios_brst", 36'(ios), 36'd0);
         @(posedge clk); #1;
         if (c == 0) cmd_valid = 1'b0;
         if (c == 2) bus_reset_req = 1'b1;
         if (c == 3) bus_reset_req = 1'b0;
      end

      // Asynchronous reset during SETTLE
      cmd_op = 2'd2; cmd_dev = 7'o066; iob_read = 36'o777000777000; cmd_valid = 1'b1;
      @(negedge clk);
      chk("arst/accept", 36'(strobes()), 36'(S_RDY));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("arst/settle", 36'(strobes()), 36'(S_FS|S_BUSY));
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk("arst/ctl", 36'(strobes()), 36'd0);
      chk("arst/ios", 36'(ios), 36'd0);
      chk("arst/wr", 36'(iob_write), 36'd0);
      chk("arst/rsp", 36'(rsp_data), 36'd0);
      npulse = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) npulse++;
      end
      chk("arst/no_rsp", 36'(npulse), 36'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("arst/ready", 36'(strobes()), 36'(S_RDY));
      @(posedge clk); #1;
      v49 = '{2'd2, 7'o066, 36'o0, 36'o777000777000, 36'o777000777000};
      run_vec(v49, "arst_coni");

      // Three back-to-back DATAOs with cmd_valid held high
      cmd_op = 2'd1; cmd_dev = 7'o010; cmd_data = 36'o252525252525; cmd_valid = 1'b1;
      npulse = 0;
      for (int c = 0; c <= 18; c++) begin
         @(negedge clk);
         chk($sformatf("b2b/rv%0d", c), 36'(rsp_valid), 36'((c % 6) == 5));
         chk($sformatf("b2b/rdy%0d", c), 36'(cmd_ready), 36'((c % 6) == 0));
         if (rsp_valid) npulse++;
         @(posedge clk); #1;
         if (c == 12) cmd_valid = 1'b0;
      end
      chk("b2b/pulses", 36'(npulse), 36'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/iobus_master_seq.md
IOBUS_MASTER_SEQ -- requirements
Module: iobus_master_seq

Interface
REQ-001 SHALL have parameter CLR_CYC, default 2, cycles that datao_clear/cono_clear are held.
REQ-002 SHALL have parameter SET_CYC, default 2, cycles that datao_set/cono_set are held.
REQ-003 SHALL have parameter SETTLE_CYC, default 3, cycles that iob_fm_datai/iob_fm_status are held before iob_read is sampled.
REQ-004 SHALL have parameter RST_CYC, default 4, cycles that iob_reset is held.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid  input  1  command request.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-009 SHALL have port cmd_op  input  2  operation: 0 = CONO, 1 = DATAO, 2 = CONI, 3 = DATAI.
REQ-010 SHALL have port cmd_dev  input  7 [3:9]  device code.
REQ-011 SHALL have port cmd_data  input  36 [0:35]  write data.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_data  output  36 [0:35]  read data; 0 for writes.
REQ-014 SHALL have port bus_reset_req  input  1  request for an IO bus reset pulse.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have ports iob_reset, datao_clear, datao_set, cono_clear, cono_set, iob_fm_datai and iob_fm_status, each output 1, as the bus strobes.
REQ-017 SHALL have port ios  output  7 [3:9]  device select.
REQ-018 SHALL have port iob_write  output  36 [0:35]  bus write data.
REQ-019 SHALL have port iob_read  input  36 [0:35]  wired-OR bus read data.

Function
REQ-020 SHALL implement states IDLE, CLR, SET, SETTLE, RESP and BRST, with one down-counter sized for the largest parameter.
REQ-021 SHALL drive cmd_ready = 1 only in IDLE, and only when neither a pending reset nor bus_reset_req is present.
REQ-022 SHALL capture op, dev and data on acceptance, and SHALL ignore cmd_* inputs while busy.
REQ-023 For a write (CONO or DATAO), SHALL transition IDLE -> CLR for CLR_CYC cycles -> SET for SET_CYC cycles -> RESP for 1 cycle -> IDLE.
REQ-024 In CLR, SHALL assert cono_clear for CONO or datao_clear for DATAO, never both.
REQ-025 In SET, SHALL assert cono_set for CONO or datao_set for DATAO, never both.
REQ-026 For a read (CONI or DATAI), SHALL transition IDLE -> SETTLE for SETTLE_CYC cycles -> RESP -> IDLE.
REQ-027 In SETTLE, SHALL assert iob_fm_status for CONI or iob_fm_datai for DATAI.
REQ-028 SHALL register iob_read into rsp_data on the last SETTLE cycle.
REQ-029 SHALL assert rsp_valid for exactly the one RESP cycle, with no backpressure.
REQ-030 SHALL keep rsp_data stable until the next RESP.
REQ-031 SHALL drive ios from the captured dev in CLR, SET, SETTLE and RESP, and SHALL drive it to 0 otherwise.
REQ-032 SHALL drive iob_write with the captured data only in CLR and SET, and SHALL drive it to 0 otherwise, including all of a read, since the bus ORs write data onto read.
REQ-033 All bus strobes SHALL be registered outputs, glitch-free, and mutually exclusive apart from ios/iob_write.
REQ-034 SHALL latch bus_reset_req into a pending flag on any cycle; a pending flag SHALL be serviced at the next IDLE, ahead of any command.
REQ-035 BRST SHALL assert iob_reset for RST_CYC cycles, then clear the pending flag and return to IDLE without a rsp_valid pulse.
REQ-036 If bus_reset_req and cmd_valid are both high in IDLE, SHALL enter BRST and leave the command unaccepted.
REQ-037 A bus_reset_req arriving mid-transaction SHALL NOT abort that transaction.
REQ-038 Back-to-back commands SHALL be accepted at the earliest in the cycle after RESP.
REQ-039 A parameter value of 0 SHALL be illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-040 While reset is low, SHALL force state to IDLE, the counter to 0, the pending flag to 0, and all outputs to 0.
REQ-041 After reset is released, cmd_ready SHALL be 1 once the state is IDLE with no request pending.
REQ-042 A reset asserted mid-operation SHALL drop all strobes asynchronously and SHALL NOT produce a rsp_valid pulse.

Structure
REQ-043 The opcode encodings and the state encoding SHALL live in the shared package iobus_pkg.
REQ-044 The block SHALL be a single module with no sub-modules; the strobe-width counter SHALL be inline.

Verification
REQ-045 Bench SHALL check: CONO, dev 7'o014, data 36'o000000000777 -> cono_clear high 2 cycles, then cono_set high 2 cycles, iob_write = 777 only during those 4 cycles, rsp_valid 1 cycle later with rsp_data = 0.
REQ-046 Bench SHALL check: DATAI, dev 7'o020, iob_read = 36'o123456701234 -> iob_fm_datai high 3 cycles, iob_write = 0 throughout, rsp_valid with rsp_data = 36'o123456701234.
REQ-047 Bench SHALL check: bus_reset_req and cmd_valid high together in IDLE -> iob_reset high 4 cycles, cmd_ready 0 throughout, then the command accepted.
REQ-048 Bench SHALL check: bus_reset_req pulsed during the SET of a DATAO -> the DATAO completes normally, then iob_reset is held 4 cycles.
REQ-049 Bench SHALL check: reset driven low during SETTLE -> all outputs 0 immediately, no rsp_valid, and the next CONI works.
REQ-050 Bench SHALL check: cmd_valid held high with 3 back-to-back DATAOs -> 3 rsp_valid pulses, each transaction 5 cycles plus 1 accept cycle.
